// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage DLX core: load-use stalls, branch flushes, data-memory waits.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int unsigned LOAD_BUBBLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  Rs1_ID,
    input  logic [4:0]  Rs2_ID,
    input  logic        use_rs1_ID,
    input  logic        use_rs2_ID,
    input  logic [4:0]  Rd_EX,
    input  logic        d_load_en_EX,
    input  logic        d_load_en_MEM,
    input  logic        d_write_en_MEM,
    input  logic        d_ready,
    input  logic        pc_cmd_EX,
    output logic        stall_IF,
    output logic        stall_ID,
    output logic        bubble_EX,
    output logic        flush_ID,
    output logic        hold_EXMEM,
    output logic        mem_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

    localparam logic [2:0] BUB_LOAD = 3'(LOAD_BUBBLES - 1);
    localparam logic [7:0] TO_LAST  = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    state_t     r_ret_state;
    logic [2:0] r_bub_cnt;
    logic [7:0] r_to_cnt;
    logic       r_mem_err;

    logic w_mem_wait;
    logic w_hz;
    logic w_timeout;

    assign w_mem_wait = (d_load_en_MEM | d_write_en_MEM) & ~d_ready;
    assign w_hz = d_load_en_EX && (Rd_EX != 5'd0) &&
                  ((use_rs1_ID && (Rs1_ID == Rd_EX)) || (use_rs2_ID && (Rs2_ID == Rd_EX)));
    // The entry cycle already counts as wait cycle 1, so the counter starts at 1.
    assign w_timeout = (r_state == MEM_WAIT) && w_mem_wait && (r_to_cnt == TO_LAST);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        stall_IF   = 1'b0;
        stall_ID   = 1'b0;
        bubble_EX  = 1'b0;
        flush_ID   = 1'b0;
        hold_EXMEM = 1'b0;
        if (reset_n) begin
            case (r_state)
                RUN, LOAD_STALL: begin
                    if (w_mem_wait) begin
                        stall_IF   = 1'b1;
                        stall_ID   = 1'b1;
                        hold_EXMEM = 1'b1;
                    end else if (r_state == LOAD_STALL) begin
                        stall_IF  = 1'b1;
                        stall_ID  = 1'b1;
                        bubble_EX = 1'b1;
                    end else if (pc_cmd_EX) begin
                        flush_ID  = 1'b1;
                        bubble_EX = 1'b1;
                    end else if (w_hz) begin
                        stall_IF  = 1'b1;
                        stall_ID  = 1'b1;
                        bubble_EX = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (w_mem_wait && !w_timeout) begin
                        stall_IF   = 1'b1;
                        stall_ID   = 1'b1;
                        hold_EXMEM = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_err = reset_n & (r_mem_err | w_timeout);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= RUN;
            r_ret_state <= RUN;
            r_bub_cnt   <= 3'd0;
            r_to_cnt    <= 8'd0;
            r_mem_err   <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_wait) begin
                        r_state     <= MEM_WAIT;
                        r_ret_state <= RUN;
                        r_to_cnt    <= 8'd1;
                    end else if (!pc_cmd_EX && w_hz && (LOAD_BUBBLES > 1)) begin
                        r_state   <= LOAD_STALL;
                        r_bub_cnt <= BUB_LOAD;
                    end
                end
                LOAD_STALL: begin
                    if (w_mem_wait) begin
                        r_state     <= MEM_WAIT;
                        r_ret_state <= LOAD_STALL;
                        r_to_cnt    <= 8'd1;
                    end else begin
                        r_bub_cnt <= r_bub_cnt - 3'd1;
                        if (r_bub_cnt == 3'd1) r_state <= RUN;
                    end
                end
                MEM_WAIT: begin
                    if (!w_mem_wait) begin
                        r_state <= r_ret_state;
                    end else if (w_timeout) begin
                        r_mem_err <= 1'b1;
                        r_state   <= r_ret_state;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (stall_IF && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (flush_ID && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule
